// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore main FSM, ALU/instr decode and conditional-write gating for the multicycle ARM core.
// Define MULTICYCLE_CTRL_MEMREADY_EN to add the MemReady input and stall FETCH/MEMRD/MEMWR until memory is ready.
module multicycle_ctrl #(
    parameter logic [3:0] FLAG_INIT = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MULTICYCLE_CTRL_MEMREADY_EN
    input  logic        MemReady,
`endif
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t state, state_n;
    logic mem_ready;
    logic [3:0] cond, rd, flags;
    logic [1:0] op, alu_ctl, flag_w;
    logic [5:0] funct;
    logic irw, next_pc, regw, memw, branch, alu_op, cond_ex, cond_q, pcs;
    logic unused_bits;

`ifdef MULTICYCLE_CTRL_MEMREADY_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // Instr carries bits [31:12] of the instruction word
    assign cond        = Instr[19:16];
    assign op          = Instr[15:14];
    assign funct       = Instr[13:8];
    assign rd          = Instr[3:0];
    assign unused_bits = ^Instr[7:4];

    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = FETCH;
        irw       = 1'b0;
        next_pc   = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state)
            FETCH: begin
                irw       = mem_ready;
                next_pc   = mem_ready;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_n   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_n   = op == 2'b01 ? MEMADR :
                            op == 2'b10 ? BRANCH :
                            op == 2'b11 ? FETCH  :
                            funct[5]    ? EXECI  : EXECR;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_n = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_n = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
            end
            MEMWR: begin
                AdrSrc  = 1'b1;
                memw    = mem_ready;
                state_n = mem_ready ? FETCH : MEMWR;
            end
            EXECR: begin
                alu_op  = 1'b1;
                state_n = ALUWB;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
                state_n = ALUWB;
            end
            ALUWB: regw = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: state_n = FETCH;
        endcase
    end

    assign alu_ctl    = funct[4:1] == 4'b0010 ? 2'b01 :
                        funct[4:1] == 4'b0000 ? 2'b10 :
                        funct[4:1] == 4'b1100 ? 2'b11 : 2'b00;
    assign ALUControl = alu_op ? alu_ctl : 2'b00;
    // C/V only follow arithmetic ops (ADD, SUB); logical ops keep them
    assign flag_w     = {funct[0], funct[0] & ~alu_ctl[1]};

    always_comb begin
        case (cond)
            4'h0: cond_ex = flags[2];
            4'h1: cond_ex = ~flags[2];
            4'h2: cond_ex = flags[1];
            4'h3: cond_ex = ~flags[1];
            4'h4: cond_ex = flags[3];
            4'h5: cond_ex = ~flags[3];
            4'h6: cond_ex = flags[0];
            4'h7: cond_ex = ~flags[0];
            4'h8: cond_ex = flags[1] & ~flags[2];
            4'h9: cond_ex = ~flags[1] | flags[2];
            4'hA: cond_ex = flags[3] == flags[0];
            4'hB: cond_ex = flags[3] != flags[0];
            4'hC: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'hD: cond_ex = flags[2] | (flags[3] != flags[0]);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags  <= FLAG_INIT;
            cond_q <= 1'b0;
        end else begin
            if (state == DECODE)
                cond_q <= cond_ex;
            if (alu_op && cond_q && flag_w[1])
                flags[3:2] <= ALUFlags[3:2];
            if (alu_op && cond_q && flag_w[0])
                flags[1:0] <= ALUFlags[1:0];
        end
    end

    assign pcs      = branch | (regw & (rd == 4'hF));
    assign PCWrite  = ~reset & (next_pc | (pcs & cond_q));
    assign RegWrite = ~reset & regw & cond_q;
    assign MemWrite = ~reset & memw & cond_q;
    assign IRWrite  = ~reset & irw;
    assign RegSrc   = {op == 2'b01 && !funct[0], op == 2'b10};
    assign ImmSrc   = op;
    assign State    = state;
endmodule
